leb128_imm_decoder: RTL and testbench

- Byte-serial LEB128 immediate decoder sitting between the genrom byte window and the core's execute stage.
- The core's fetch unit starts it on `i32.const`/`i64.const` and on memarg/index immediates, then streams opcode-following bytes into it.
- It returns a width-checked value that is pushed onto the operand stack, e.g. the i64 operand later consumed by `f64.reinterpret_i64`.
- It returns a trap code instead when the encoding is illegal.

---
 rtl/leb128_pkg.sv | 29 ++
 rtl/leb128_pad_check.sv | 33 +++
 rtl/leb128_imm_decoder.sv | 175 +++++++++++++++++
 tb/tb_leb128_imm_decoder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leb128_pkg.sv
// rtl/leb128_pkg.sv - shared types and constants for the LEB128 immediate decoder
//
// Purpose: the decoder state enum, the trap codes and the per-width byte
// limits. The type and NO_64B encodings mirror the core's definitions so
// the core can forward out_type/out_trap without remapping them.
package leb128_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } leb_state_e;

  // Operand type encodings, identical to the core's `i32/`i64 values.
  localparam logic [1:0] TYPE_I32 = 2'd0;
  localparam logic [1:0] TYPE_I64 = 2'd1;

  localparam logic [3:0] LEB_OK       = 4'd0;
  localparam logic [3:0] LEB_OVERFLOW = 4'd1;
  localparam logic [3:0] LEB_BAD_PAD  = 4'd2;
  // Same value as the core's NO_64B trap so it passes straight through.
  localparam logic [3:0] TRAP_NO_64B  = 4'd7;

  // Maximum encoded length for each immediate width.
  localparam int unsigned N_I32 = 5;
  localparam int unsigned N_I64 = 10;

endpackage

// File: rtl/leb128_pad_check.sv
// rtl/leb128_pad_check.sv - padding check for the last legal byte of an immediate
//
// Purpose: when the final byte is the widest allowed byte, the payload bits
// above the value width must be zero (unsigned) or a copy of the sign bit
// (signed). Purely combinational.
// Ports:
//   byte_i      payload bits [6:0] of the final byte
//   is_64_i     1 = i64 immediate, 0 = i32
//   is_signed_i 1 = sLEB128, 0 = uLEB128
//   pad_ok_o    1 when the unused high bits are legal
module leb128_pad_check
  import leb128_pkg::*;
(
  input  logic [6:0] byte_i,
  input  logic       is_64_i,
  input  logic       is_signed_i,
  output logic       pad_ok_o
);

  always_comb begin
    pad_ok_o = 1'b0;
    if (is_64_i) begin
      // Byte 10 carries only value bit 63 in bit 0.
      if (is_signed_i) pad_ok_o = (byte_i[6:1] == {6{byte_i[0]}});
      else             pad_ok_o = (byte_i[6:1] == 6'd0);
    end else begin
      // Byte 5 carries value bits 31:28 in bits 3:0.
      if (is_signed_i) pad_ok_o = (byte_i[6:4] == {3{byte_i[3]}});
      else             pad_ok_o = (byte_i[6:4] == 3'd0);
    end
  end

endmodule

// File: rtl/leb128_imm_decoder.sv
// rtl/leb128_imm_decoder.sv - byte-serial LEB128 immediate decoder
//
// Purpose: accepts a start request for an i32/i64, signed/unsigned immediate,
// consumes the encoded bytes one per handshake and presents either the
// width-checked value or a trap code until the consumer takes it.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start/is_64/is_signed  request, honoured only in IDLE
//   in_valid/in_ready/in_byte  byte stream handshake
//   out_valid/out_ready    result handshake
//   out_value/out_type/out_len/out_trap  registered result fields
module leb128_imm_decoder
  import leb128_pkg::*;
#(
  parameter bit          USE_64B   = 1'b1,
  parameter int unsigned MAX_BYTES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_64,
  input  logic        is_signed,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_value,
  output logic [1:0]  out_type,
  output logic [3:0]  out_len,
  output logic [3:0]  out_trap
);

  // Continuation-bit limit: the natural width limit, further capped by MAX_BYTES.
  localparam int unsigned LIM32 = (MAX_BYTES < N_I32) ? MAX_BYTES : N_I32;
  localparam int unsigned LIM64 = (MAX_BYTES < N_I64) ? MAX_BYTES : N_I64;

  leb_state_e  state_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [63:0] out_value_q;
  logic [1:0]  out_type_q;
  logic [3:0]  out_len_q;
  logic [3:0]  out_trap_q;
  logic        is64_q;
  logic        signed_q;
  logic [63:0] acc_q;
  logic [3:0]  cnt_q;

  logic        xfer;
  logic [3:0]  cnt_d;
  logic [63:0] acc_d;
  logic [63:0] value_d;
  logic [6:0]  shamt;
  logic [6:0]  fill_shamt;
  logic [6:0]  width_bits;
  logic [3:0]  lim_m1;
  logic [3:0]  width_m1;
  logic        pad_ok;

  assign xfer       = in_valid && in_ready_q && (state_q == ACCUM);
  assign cnt_d      = cnt_q + 4'd1;
  assign shamt      = 7'(cnt_q) * 7'd7;
  assign fill_shamt = 7'(cnt_d) * 7'd7;
  assign width_bits = is64_q ? 7'd64 : 7'd32;
  assign lim_m1     = is64_q ? 4'(LIM64 - 1) : 4'(LIM32 - 1);
  assign width_m1   = is64_q ? 4'(N_I64 - 1) : 4'(N_I32 - 1);

  // Payload bits that land above bit 63 are simply shifted out.
  assign acc_d = acc_q | (64'(in_byte[6:0]) << shamt);

  always_comb begin
    value_d = acc_d;
    // Sign-extend from the first bit past the payload collected so far.
    if (signed_q && in_byte[6] && (fill_shamt < width_bits)) begin
      value_d = acc_d | (~64'd0 << fill_shamt[5:0]);
    end
    if (!is64_q) value_d[63:32] = 32'd0;
  end

  leb128_pad_check u_pad_check (
    .byte_i      (in_byte[6:0]),
    .is_64_i     (is64_q),
    .is_signed_i (signed_q),
    .pad_ok_o    (pad_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_value_q <= 64'd0;
      out_type_q  <= TYPE_I32;
      out_len_q   <= 4'd0;
      out_trap_q  <= LEB_OK;
      is64_q      <= 1'b0;
      signed_q    <= 1'b0;
      acc_q       <= 64'd0;
      cnt_q       <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b0;
          if (start) begin
            out_type_q <= is_64 ? TYPE_I64 : TYPE_I32;
            if (is_64 && !USE_64B) begin
              state_q     <= ERR;
              out_valid_q <= 1'b1;
              out_value_q <= 64'd0;
              out_len_q   <= 4'd0;
              out_trap_q  <= TRAP_NO_64B;
            end else begin
              state_q    <= ACCUM;
              in_ready_q <= 1'b1;
              is64_q     <= is_64;
              signed_q   <= is_signed;
              acc_q      <= 64'd0;
              cnt_q      <= 4'd0;
            end
          end
        end

        ACCUM: begin
          if (xfer) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (in_byte[7]) begin
              if (cnt_q == lim_m1) begin
                state_q     <= ERR;
                in_ready_q  <= 1'b0;
                out_valid_q <= 1'b1;
                out_value_q <= 64'd0;
                out_len_q   <= cnt_d;
                out_trap_q  <= LEB_OVERFLOW;
              end
            end else begin
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_len_q   <= cnt_d;
              // Padding only constrains the widest possible final byte.
              if ((cnt_q == width_m1) && !pad_ok) begin
                state_q     <= ERR;
                out_value_q <= 64'd0;
                out_trap_q  <= LEB_BAD_PAD;
              end else begin
                state_q     <= DONE;
                out_value_q <= value_d;
                out_trap_q  <= LEB_OK;
              end
            end
          end
        end

        DONE, ERR: begin
          in_ready_q <= 1'b0;
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign out_type  = out_type_q;
  assign out_len   = out_len_q;
  assign out_trap  = out_trap_q;

endmodule

// File: tb/tb_leb128_imm_decoder.sv
// tb/tb_leb128_imm_decoder.sv - self-checking bench for leb128_imm_decoder
module tb_leb128_imm_decoder;
  import leb128_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, start = 1'b0, is_64 = 1'b0, is_signed = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_byte = 8'd0;
  logic        in_ready, out_valid;
  logic [63:0] out_value;
  logic [1:0]  out_type;
  logic [3:0]  out_len, out_trap;

  logic        b_start = 1'b0, b_is_64 = 1'b0, b_is_signed = 1'b0;
  logic        b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [7:0]  b_in_byte = 8'h80;
  logic        b_in_ready, b_out_valid;
  logic [63:0] b_out_value;
  logic [1:0]  b_out_type;
  logic [3:0]  b_out_len, b_out_trap;
  bit          b_ready_seen = 1'b0;

  leb128_imm_decoder #(.USE_64B(1'b1), .MAX_BYTES(10)) u_dut (
    .clk(clk), .reset(reset), .start(start), .is_64(is_64), .is_signed(is_signed),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_type(out_type), .out_len(out_len), .out_trap(out_trap)
  );

  leb128_imm_decoder #(.USE_64B(1'b0), .MAX_BYTES(5)) u_dut32 (
    .clk(clk), .reset(reset), .start(b_start), .is_64(b_is_64), .is_signed(b_is_signed),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_byte(b_in_byte),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_value(b_out_value),
    .out_type(b_out_type), .out_len(b_out_len), .out_trap(b_out_trap)
  );

  always @(posedge clk) if (b_in_ready) b_ready_seen <= 1'b1;

  typedef struct packed {
    logic [63:0] v;
    logic [1:0]  t;
    logic [3:0]  l;
    logic [3:0]  tr;
  } exp_t;

  typedef struct packed {
    logic        i64;
    logic        sg;
    logic [3:0]  n;
    logic [79:0] b;
    logic [63:0] v;
    logic [3:0]  tr;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic i64, input logic sg);
    start = 1'b1; is_64 = i64; is_signed = sg;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    in_valid = 1'b1; in_byte = b;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_byte_timeout byte=%h in_ready never seen", b);
    end
  endtask

  task automatic wait_out();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL wait_out_timeout out_valid never asserted");
    end
  endtask

  task automatic take_result(output exp_t got);
    got = {out_value, out_type, out_len, out_trap};
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic drive_vec(input vec_t vc);
    sb.push_back('{vc.v, vc.i64 ? TYPE_I64 : TYPE_I32, vc.n, vc.tr});
    start_req(vc.i64, vc.sg);
    for (int k = 0; k < int'(vc.n); k++) send_byte(vc.b[8*k +: 8]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_value !== 64'd0) begin failures++; $display("FAIL reset_out_value got=%h exp=0", out_value); end
    checks++; if (out_type !== TYPE_I32) begin failures++; $display("FAIL reset_out_type got=%0d exp=%0d", out_type, TYPE_I32); end
    checks++; if (out_len !== 4'd0) begin failures++; $display("FAIL reset_out_len got=%0d exp=0", out_len); end
    checks++; if (out_trap !== 4'd0) begin failures++; $display("FAIL reset_out_trap got=%0d exp=0", out_trap); end
  endtask

  task automatic test_decode();
    vec_t tbl[7];
    exp_t got, exp;
    tbl[0] = '{1'b0, 1'b0, 4'd3,  80'h268EE5,                 64'h0000000000098765, LEB_OK};
    tbl[1] = '{1'b1, 1'b1, 4'd9,  80'h408080808080808080,     64'hC000000000000000, LEB_OK};
    tbl[2] = '{1'b1, 1'b1, 4'd1,  80'h7F,                     64'hFFFFFFFFFFFFFFFF, LEB_OK};
    tbl[3] = '{1'b0, 1'b1, 4'd1,  80'h7F,                     64'h00000000FFFFFFFF, LEB_OK};
    tbl[4] = '{1'b0, 1'b0, 4'd5,  80'h0FFFFFFFFF,             64'h00000000FFFFFFFF, LEB_OK};
    tbl[5] = '{1'b0, 1'b1, 4'd5,  80'h7880808080,             64'h0000000080000000, LEB_OK};
    tbl[6] = '{1'b1, 1'b0, 4'd10, 80'h01FFFFFFFFFFFFFFFFFF,   64'hFFFFFFFFFFFFFFFF, LEB_OK};
    for (int i = 0; i < 7; i++) begin
      drive_vec(tbl[i]);
      wait_out();
      take_result(got);
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL decode_%0d got v=%h t=%0d l=%0d tr=%0d exp v=%h t=%0d l=%0d tr=%0d",
                 i, got.v, got.t, got.l, got.tr, exp.v, exp.t, exp.l, exp.tr);
      end
    end
  endtask

  task automatic test_errors();
    vec_t tbl[5];
    exp_t got, exp;
    tbl[0] = '{1'b0, 1'b0, 4'd5,  80'h1FFFFFFFFF,             64'd0, LEB_BAD_PAD};
    tbl[1] = '{1'b0, 1'b0, 4'd5,  80'hFFFFFFFFFF,             64'd0, LEB_OVERFLOW};
    tbl[2] = '{1'b0, 1'b1, 4'd5,  80'h7080808080,             64'd0, LEB_BAD_PAD};
    tbl[3] = '{1'b1, 1'b0, 4'd10, 80'h02FFFFFFFFFFFFFFFFFF,   64'd0, LEB_BAD_PAD};
    tbl[4] = '{1'b1, 1'b0, 4'd10, 80'hFFFFFFFFFFFFFFFFFFFF,   64'd0, LEB_OVERFLOW};
    for (int i = 0; i < 5; i++) begin
      drive_vec(tbl[i]);
      wait_out();
      take_result(got);
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL error_%0d got v=%h t=%0d l=%0d tr=%0d exp v=%h t=%0d l=%0d tr=%0d",
                 i, got.v, got.t, got.l, got.tr, exp.v, exp.t, exp.l, exp.tr);
      end
    end
  endtask

  task automatic test_no_64b();
    exp_t got, exp;
    sb.push_back('{64'd0, TYPE_I64, 4'd0, TRAP_NO_64B});
    b_in_valid = 1'b1;
    b_start = 1'b1; b_is_64 = 1'b1; b_is_signed = 1'b1;
    tick();
    b_start = 1'b0;
    got = {b_out_value, b_out_type, b_out_len, b_out_trap};
    exp = sb.pop_front();
    checks++;
    if (b_out_valid !== 1'b1 || got !== exp) begin
      failures++;
      $display("FAIL no64b_result valid=%b v=%h t=%0d l=%0d tr=%0d exp valid=1 v=%h t=%0d l=%0d tr=%0d",
               b_out_valid, got.v, got.t, got.l, got.tr, exp.v, exp.t, exp.l, exp.tr);
    end
    tick(); tick();
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    b_in_valid = 1'b0;
    checks++;
    if (b_out_valid !== 1'b0) begin failures++; $display("FAIL no64b_release out_valid got=%b exp=0", b_out_valid); end
    checks++;
    if (b_ready_seen !== 1'b0) begin failures++; $display("FAIL no64b_in_ready seen=%b exp=0", b_ready_seen); end
  endtask

  task automatic test_backpressure();
    exp_t got, exp;
    sb.push_back('{64'h98765, TYPE_I32, 4'd3, LEB_OK});
    start_req(1'b0, 1'b0);
    send_byte(8'hE5); tick();
    send_byte(8'h8E); tick();
    send_byte(8'h26);
    // Offer a stray byte while the result is held.
    in_valid = 1'b1; in_byte = 8'h01;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_value !== 64'h98765 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_%0d valid=%b value=%h in_ready=%b exp valid=1 value=98765 in_ready=0",
                 i, out_valid, out_value, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    take_result(got);
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL backpressure got v=%h l=%0d tr=%0d exp v=%h l=%0d tr=%0d", got.v, got.l, got.tr, exp.v, exp.l, exp.tr);
    end
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_ready out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    exp_t got, exp;
    start_req(1'b0, 1'b0);
    send_byte(8'hFF);
    send_byte(8'hFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid valid=%b in_ready=%b exp 0 0", out_valid, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_mid_quiet out_valid got=%b exp=0", out_valid); end
    sb.push_back('{64'h00000000FFFFFFFF, TYPE_I32, 4'd1, LEB_OK});
    start_req(1'b0, 1'b1);
    send_byte(8'h7F);
    wait_out();
    take_result(got);
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset_mid_fresh got v=%h l=%0d tr=%0d exp v=%h l=%0d tr=%0d", got.v, got.l, got.tr, exp.v, exp.l, exp.tr);
    end
  endtask

  task automatic test_back_to_back();
    exp_t got, exp;
    logic [7:0] bytes[3] = '{8'h05, 8'h7E, 8'h3F};
    logic       sgn[3]   = '{1'b0, 1'b1, 1'b0};
    logic [63:0] vals[3] = '{64'h5, 64'h00000000FFFFFFFE, 64'h3F};
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{vals[i], TYPE_I32, 4'd1, LEB_OK});
      start_req(1'b0, sgn[i]);
      in_valid = 1'b1; in_byte = bytes[i];
      tick();
      in_valid = 1'b0;
      // Result must appear the cycle right after the final byte.
      got = {out_value, out_type, out_len, out_trap};
      exp = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || got !== exp) begin
        failures++;
        $display("FAIL b2b_%0d valid=%b v=%h l=%0d tr=%0d exp valid=1 v=%h l=%0d tr=%0d",
                 i, out_valid, got.v, got.l, got.tr, exp.v, exp.l, exp.tr);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_errors();
    test_no_64b();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover entries=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
